// File: rtl/mem_arbiter.sv
// Purpose: serialises single-beat CPU/PPU memory requests onto the shared memory bus (PPU priority, CPU anti-starvation).
// Latency: req in cycle T -> bus strobe in T+1 at the earliest -> ack (and read data) in T+2.
// Backpressure: one pending slot per port; busy is high while the slot is occupied, and a req seen while busy is dropped and flagged as overrun. Nothing is granted while load_done is low.
// Optional feature: define MEM_ARB_ROM_WP_EN to suppress bus writes into the PRG ROM region (addr[21] == 0).
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_done,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [21:0] cpu_addr,
    input  logic [7:0]  cpu_d,
    output logic [7:0]  cpu_q,
    output logic        cpu_ack,
    output logic        cpu_busy,
    output logic        cpu_overrun,

    input  logic        ppu_req,
    input  logic        ppu_we,
    input  logic [21:0] ppu_addr,
    input  logic [7:0]  ppu_d,
    output logic [7:0]  ppu_q,
    output logic        ppu_ack,
    output logic        ppu_busy,
    output logic        ppu_overrun,

    output logic [21:0] mem_addr,
    output logic        mem_rd_cpu,
    output logic        mem_rd_ppu,
    output logic        mem_wr,
    output logic [7:0]  mem_d,
    input  logic [7:0]  mem_q_cpu,
    input  logic [7:0]  mem_q_ppu
);

    localparam logic [3:0] WAIT_MAX = 4'(STARVE_LIMIT);

    // Pending request slots, one per port.
    logic        cpu_pend;
    logic        cpu_slot_we;
    logic [21:0] cpu_slot_addr;
    logic [7:0]  cpu_slot_d;
    logic        ppu_pend;
    logic        ppu_slot_we;
    logic [21:0] ppu_slot_addr;
    logic [7:0]  ppu_slot_d;

    // In-flight flags double as the ack pulses.
    logic        cpu_flight;
    logic        ppu_flight;

    logic        cpu_ovr;
    logic        ppu_ovr;
    logic [3:0]  cpu_wait;

    // Bus address/data are held between grants.
    logic [21:0] hold_addr;
    logic [7:0]  hold_d;

    logic        cpu_grant;
    logic        ppu_grant;
    logic        any_grant;
    logic        sel_we;
    logic [21:0] sel_addr;
    logic [7:0]  sel_d;
    logic        wr_allow;

    // Grant selection: PPU first, unless the CPU has waited its full starvation limit.
    always_comb begin
        cpu_grant = 1'b0;
        ppu_grant = 1'b0;
        if (load_done) begin
            if (cpu_pend && (!ppu_pend || cpu_wait == WAIT_MAX)) begin
                cpu_grant = 1'b1;
            end else if (ppu_pend) begin
                ppu_grant = 1'b1;
            end
        end
    end

    assign any_grant = cpu_grant | ppu_grant;

    // Mux the granted slot onto the bus; hold the last address/data when idle.
    always_comb begin
        sel_we   = ppu_slot_we;
        sel_addr = ppu_slot_addr;
        sel_d    = ppu_slot_d;
        if (cpu_grant) begin
            sel_we   = cpu_slot_we;
            sel_addr = cpu_slot_addr;
            sel_d    = cpu_slot_d;
        end
    end

`ifdef MEM_ARB_ROM_WP_EN
    // The lower half of the address space is PRG ROM: writes there are consumed but never strobed.
    assign wr_allow = sel_addr[21];
`else
    assign wr_allow = 1'b1;
`endif

    assign mem_addr   = any_grant ? sel_addr : hold_addr;
    assign mem_d      = any_grant ? sel_d : hold_d;
    assign mem_wr     = any_grant & sel_we & wr_allow;
    assign mem_rd_cpu = cpu_grant & ~cpu_slot_we;
    assign mem_rd_ppu = ppu_grant & ~ppu_slot_we;

    assign cpu_busy    = cpu_pend;
    assign ppu_busy    = ppu_pend;
    assign cpu_ack     = cpu_flight;
    assign ppu_ack     = ppu_flight;
    assign cpu_overrun = cpu_ovr;
    assign ppu_overrun = ppu_ovr;
    assign cpu_q       = mem_q_cpu;
    assign ppu_q       = mem_q_ppu;

    // CPU slot: capture when free, release on grant, flag requests that arrive while occupied.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_pend      <= 1'b0;
            cpu_slot_we   <= 1'b0;
            cpu_slot_addr <= '0;
            cpu_slot_d    <= '0;
            cpu_ovr       <= 1'b0;
        end else begin
            if (cpu_req && !cpu_pend) begin
                cpu_pend      <= 1'b1;
                cpu_slot_we   <= cpu_we;
                cpu_slot_addr <= cpu_addr;
                cpu_slot_d    <= cpu_d;
            end else if (cpu_grant) begin
                cpu_pend <= 1'b0;
            end
            if (cpu_req && cpu_pend) begin
                cpu_ovr <= 1'b1;
            end
        end
    end

    // PPU slot: same capture/release/overrun rules as the CPU slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ppu_pend      <= 1'b0;
            ppu_slot_we   <= 1'b0;
            ppu_slot_addr <= '0;
            ppu_slot_d    <= '0;
            ppu_ovr       <= 1'b0;
        end else begin
            if (ppu_req && !ppu_pend) begin
                ppu_pend      <= 1'b1;
                ppu_slot_we   <= ppu_we;
                ppu_slot_addr <= ppu_addr;
                ppu_slot_d    <= ppu_d;
            end else if (ppu_grant) begin
                ppu_pend <= 1'b0;
            end
            if (ppu_req && ppu_pend) begin
                ppu_ovr <= 1'b1;
            end
        end
    end

    // CPU starvation counter: counts cycles pending without a grant, saturating at the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_wait <= '0;
        end else if (cpu_grant) begin
            cpu_wait <= '0;
        end else if (cpu_pend && cpu_wait != WAIT_MAX) begin
            cpu_wait <= cpu_wait + 4'd1;
        end
    end

    // Completion tracking and bus hold registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_flight <= 1'b0;
            ppu_flight <= 1'b0;
            hold_addr  <= '0;
            hold_d     <= '0;
        end else begin
            cpu_flight <= cpu_grant;
            ppu_flight <= ppu_grant;
            if (any_grant) begin
                hold_addr <= sel_addr;
                hold_d    <= sel_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int LIMIT = 4;
`ifdef MEM_ARB_ROM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_done = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [21:0] cpu_addr = '0;
    logic [7:0]  cpu_d = '0;
    logic [7:0]  cpu_q;
    logic        cpu_ack, cpu_busy, cpu_overrun;
    logic        ppu_req = 1'b0, ppu_we = 1'b0;
    logic [21:0] ppu_addr = '0;
    logic [7:0]  ppu_d = '0;
    logic [7:0]  ppu_q;
    logic        ppu_ack, ppu_busy, ppu_overrun;
    logic [21:0] mem_addr;
    logic        mem_rd_cpu, mem_rd_ppu, mem_wr;
    logic [7:0]  mem_d;
    logic [7:0]  mem_q_cpu = 8'h00;
    logic [7:0]  mem_q_ppu = 8'h00;

    int checks = 0;
    int passed = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset), .load_done(load_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy), .cpu_overrun(cpu_overrun),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_d(ppu_d),
        .ppu_q(ppu_q), .ppu_ack(ppu_ack), .ppu_busy(ppu_busy), .ppu_overrun(ppu_overrun),
        .mem_addr(mem_addr), .mem_rd_cpu(mem_rd_cpu), .mem_rd_ppu(mem_rd_ppu),
        .mem_wr(mem_wr), .mem_d(mem_d), .mem_q_cpu(mem_q_cpu), .mem_q_ppu(mem_q_ppu)
    );

    always #5 clock = ~clock;

    // Responder: read data is a fixed function of address, one cycle after the read strobe.
    function automatic logic [7:0] resp_fn(input int port, input logic [21:0] a);
        return (port == 0) ? (8'hA0 ^ a[7:0]) : (8'h5A ^ a[7:0]);
    endfunction

    always @(posedge clock) begin
        if (mem_rd_cpu) mem_q_cpu <= resp_fn(0, mem_addr);
        if (mem_rd_ppu) mem_q_ppu <= resp_fn(1, mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model: port-indexed (0 = CPU, 1 = PPU) ----------------
    typedef struct {
        bit          pend;
        bit          we;
        logic [21:0] addr;
        logic [7:0]  d;
    } slot_t;

    slot_t       m_slot[2];
    bit          m_fl[2];
    bit          m_fl_rd[2];
    logic [21:0] m_fl_addr[2];
    bit          m_ovr[2];
    int          m_wait;
    logic [21:0] m_hold_addr;
    logic [7:0]  m_hold_d;

    function automatic bit wr_ok(input logic [21:0] a);
        return WP_ON ? a[21] : 1'b1;
    endfunction

    // Which port owns the bus this cycle, or -1 for none.
    function automatic int m_winner();
        bit cpu_due;
        if (!load_done) return -1;
        cpu_due = m_slot[0].pend && (m_wait >= LIMIT);
        if (m_slot[1].pend && !cpu_due) return 1;
        if (m_slot[0].pend) return 0;
        return -1;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 2; p++) begin
            m_slot[p] = '{pend: 1'b0, we: 1'b0, addr: 22'h0, d: 8'h00};
            m_fl[p] = 1'b0; m_fl_rd[p] = 1'b0; m_fl_addr[p] = 22'h0; m_ovr[p] = 1'b0;
        end
        m_wait = 0; m_hold_addr = 22'h0; m_hold_d = 8'h00;
    endtask

    task automatic model_check();
        int w;
        bit erc, erp, ewr;
        logic [21:0] ea;
        logic [7:0] ed;
        if (!reset) model_clear();
        w = m_winner();
        erc = 1'b0; erp = 1'b0; ewr = 1'b0; ea = m_hold_addr; ed = m_hold_d;
        if (w >= 0) begin
            ea = m_slot[w].addr;
            ed = m_slot[w].d;
            if (m_slot[w].we) ewr = wr_ok(ea);
            else if (w == 0) erc = 1'b1;
            else erp = 1'b1;
        end
        chk("m_rd_cpu", mem_rd_cpu, erc);
        chk("m_rd_ppu", mem_rd_ppu, erp);
        chk("m_wr", mem_wr, ewr);
        chk("m_addr", mem_addr, ea);
        chk("m_d", mem_d, ed);
        chk("m_cpu_ack", cpu_ack, m_fl[0]);
        chk("m_ppu_ack", ppu_ack, m_fl[1]);
        chk("m_cpu_busy", cpu_busy, m_slot[0].pend);
        chk("m_ppu_busy", ppu_busy, m_slot[1].pend);
        chk("m_cpu_ovr", cpu_overrun, m_ovr[0]);
        chk("m_ppu_ovr", ppu_overrun, m_ovr[1]);
        if (m_fl[0] && m_fl_rd[0]) chk("m_cpu_q", cpu_q, resp_fn(0, m_fl_addr[0]));
        if (m_fl[1] && m_fl_rd[1]) chk("m_ppu_q", ppu_q, resp_fn(1, m_fl_addr[1]));
    endtask

    task automatic model_advance();
        int w;
        bit old_pend[2];
        bit rq[2], wq[2];
        logic [21:0] aq[2];
        logic [7:0] dq[2];
        if (!reset) begin
            model_clear();
            return;
        end
        rq[0] = cpu_req; wq[0] = cpu_we; aq[0] = cpu_addr; dq[0] = cpu_d;
        rq[1] = ppu_req; wq[1] = ppu_we; aq[1] = ppu_addr; dq[1] = ppu_d;
        w = m_winner();
        if (w == 0) m_wait = 0;
        else if (m_slot[0].pend) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
        if (w >= 0) begin
            m_hold_addr = m_slot[w].addr;
            m_hold_d = m_slot[w].d;
        end
        for (int p = 0; p < 2; p++) begin
            old_pend[p] = m_slot[p].pend;
            m_fl[p] = (w == p);
            m_fl_rd[p] = (w == p) && !m_slot[p].we;
            if (w == p) begin
                m_fl_addr[p] = m_slot[p].addr;
                m_slot[p].pend = 1'b0;
            end
            if (rq[p]) begin
                if (old_pend[p]) m_ovr[p] = 1'b1;
                else m_slot[p] = '{pend: 1'b1, we: wq[p], addr: aq[p], d: dq[p]};
            end
        end
    endtask

    task automatic sample();
        @(negedge clock);
        model_check();
    endtask

    task automatic advance();
        @(posedge clock);
        model_advance();
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 22'h0; cpu_d = 8'h00;
        ppu_req = 1'b0; ppu_we = 1'b0; ppu_addr = 22'h0; ppu_d = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        repeat (2) begin sample(); advance(); end
        reset = 1'b1;
    endtask

    // ---------------- directed vector table (CPU/PPU reads, load_done high) ----------------
    typedef struct {
        bit          ld;
        bit          creq;
        logic [21:0] caddr;
        bit          preq;
        logic [21:0] paddr;
        bit          e_rdc;
        bit          e_rdp;
        logic [21:0] e_addr;
        bit          e_cack;
        bit          e_pack;
        bit          e_cbusy;
        bit          e_pbusy;
        logic [7:0]  e_cq;
        logic [7:0]  e_pq;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl[NV];

    int n_cack, n_pack;
    logic [31:0] exp_wr;

    initial begin
        tbl[0]  = '{1, 1, 22'h3C0005, 0, 22'h0,      0, 0, 22'h000000, 0, 0, 0, 0, 8'h00, 8'h00};
        tbl[1]  = '{1, 0, 22'h0,      0, 22'h0,      1, 0, 22'h3C0005, 0, 0, 1, 0, 8'h00, 8'h00};
        tbl[2]  = '{1, 0, 22'h0,      0, 22'h0,      0, 0, 22'h3C0005, 1, 0, 0, 0, 8'hA5, 8'h00};
        tbl[3]  = '{1, 1, 22'h110001, 1, 22'h220002, 0, 0, 22'h3C0005, 0, 0, 0, 0, 8'h00, 8'h00};
        tbl[4]  = '{1, 0, 22'h0,      0, 22'h0,      0, 1, 22'h220002, 0, 0, 1, 1, 8'h00, 8'h00};
        tbl[5]  = '{1, 0, 22'h0,      0, 22'h0,      1, 0, 22'h110001, 0, 1, 1, 0, 8'h00, 8'h58};
        tbl[6]  = '{1, 0, 22'h0,      0, 22'h0,      0, 0, 22'h110001, 1, 0, 0, 0, 8'hA1, 8'h00};
        tbl[7]  = '{1, 1, 22'h330003, 0, 22'h0,      0, 0, 22'h110001, 0, 0, 0, 0, 8'h00, 8'h00};
        tbl[8]  = '{1, 0, 22'h0,      0, 22'h0,      1, 0, 22'h330003, 0, 0, 1, 0, 8'h00, 8'h00};
        tbl[9]  = '{1, 1, 22'h330004, 0, 22'h0,      0, 0, 22'h330003, 1, 0, 0, 0, 8'hA3, 8'h00};
        tbl[10] = '{1, 0, 22'h0,      0, 22'h0,      1, 0, 22'h330004, 0, 0, 1, 0, 8'h00, 8'h00};
        tbl[11] = '{1, 0, 22'h0,      0, 22'h0,      0, 0, 22'h330004, 1, 0, 0, 0, 8'hA4, 8'h00};

        model_clear();

        // Reset state.
        do_reset();
        sample();
        chk("rst_busy", {cpu_busy, ppu_busy}, 2'b00);
        chk("rst_ack", {cpu_ack, ppu_ack}, 2'b00);
        chk("rst_strobes", {mem_rd_cpu, mem_rd_ppu, mem_wr}, 3'b000);
        chk("rst_addr", mem_addr, 22'h0);
        advance();

        // Table: single read, simultaneous requests, back-to-back CPU reads.
        for (int i = 0; i < NV; i++) begin
            load_done = tbl[i].ld;
            cpu_req = tbl[i].creq; cpu_we = 1'b0; cpu_addr = tbl[i].caddr; cpu_d = 8'h00;
            ppu_req = tbl[i].preq; ppu_we = 1'b0; ppu_addr = tbl[i].paddr; ppu_d = 8'h00;
            sample();
            chk($sformatf("tbl%0d_rd_cpu", i), mem_rd_cpu, tbl[i].e_rdc);
            chk($sformatf("tbl%0d_rd_ppu", i), mem_rd_ppu, tbl[i].e_rdp);
            chk($sformatf("tbl%0d_wr", i), mem_wr, 1'b0);
            chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_cpu_ack", i), cpu_ack, tbl[i].e_cack);
            chk($sformatf("tbl%0d_ppu_ack", i), ppu_ack, tbl[i].e_pack);
            chk($sformatf("tbl%0d_cpu_busy", i), cpu_busy, tbl[i].e_cbusy);
            chk($sformatf("tbl%0d_ppu_busy", i), ppu_busy, tbl[i].e_pbusy);
            if (tbl[i].e_cack) chk($sformatf("tbl%0d_cpu_q", i), cpu_q, tbl[i].e_cq);
            if (tbl[i].e_pack) chk($sformatf("tbl%0d_ppu_q", i), ppu_q, tbl[i].e_pq);
            advance();
        end
        idle();

        // Write held off while load_done is low, issued as soon as it rises.
        load_done = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h380010; cpu_d = 8'h3C;
        sample(); advance();
        idle();
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("ld_low_wr", mem_wr, 1'b0);
            chk("ld_low_busy", cpu_busy, 1'b1);
            advance();
        end
        load_done = 1'b1;
        sample();
        chk("ld_rise_wr", mem_wr, 1'b1);
        chk("ld_rise_addr", mem_addr, 22'h380010);
        chk("ld_rise_d", mem_d, 8'h3C);
        advance();
        sample();
        chk("ld_rise_ack", cpu_ack, 1'b1);
        advance();

        // Starvation: both pending while load_done is low; CPU has waited its limit and goes first.
        load_done = 1'b0;
        cpu_req = 1'b1; cpu_addr = 22'h050505;
        ppu_req = 1'b1; ppu_addr = 22'h060606;
        sample(); advance();
        idle();
        repeat (5) begin sample(); advance(); end
        load_done = 1'b1;
        sample();
        chk("starve_cpu_first", {mem_rd_cpu, mem_rd_ppu}, 2'b10);
        advance();
        sample();
        chk("starve_ppu_next", {mem_rd_cpu, mem_rd_ppu}, 2'b01);
        chk("starve_cpu_ack", cpu_ack, 1'b1);
        chk("starve_cpu_q", cpu_q, 8'hA5);
        advance();
        sample();
        chk("starve_ppu_ack", ppu_ack, 1'b1);
        advance();

        // PPU requesting every other cycle alongside one CPU request: nothing lost.
        n_cack = 0; n_pack = 0;
        for (int k = 0; k < 14; k++) begin
            idle();
            if (k < 10 && k % 2 == 0) begin ppu_req = 1'b1; ppu_addr = 22'(22'h100 + k); end
            if (k == 0) begin cpu_req = 1'b1; cpu_addr = 22'h2A0000; end
            sample();
            n_cack += int'(cpu_ack);
            n_pack += int'(ppu_ack);
            advance();
        end
        chk("stream_ppu_acks", n_pack, 5);
        chk("stream_cpu_acks", n_cack, 1);
        chk("stream_ppu_ovr", ppu_overrun, 1'b0);

        // Overrun: second CPU request while the first is still pending.
        cpu_req = 1'b1; cpu_addr = 22'h010000;
        sample(); advance();
        cpu_addr = 22'h020000;
        sample();
        chk("ovr_grant_addr", mem_addr, 22'h010000);
        chk("ovr_not_yet", cpu_overrun, 1'b0);
        advance();
        idle();
        sample();
        chk("ovr_ack", cpu_ack, 1'b1);
        chk("ovr_q", cpu_q, 8'hA0);
        chk("ovr_flag", cpu_overrun, 1'b1);
        advance();
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("ovr_no_second", mem_rd_cpu, 1'b0);
            chk("ovr_sticky", cpu_overrun, 1'b1);
            advance();
        end

        // Write into the PRG ROM region.
        exp_wr = WP_ON ? 32'd0 : 32'd1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h001234; cpu_d = 8'h77;
        sample(); advance();
        idle();
        sample();
        chk("rom_wr", mem_wr, exp_wr);
        chk("rom_addr", mem_addr, 22'h001234);
        advance();
        sample();
        chk("rom_ack", cpu_ack, 1'b1);
        advance();

        // Reset in the grant cycle discards the request; reset in the ack cycle kills the ack.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h0A0A0A;
        sample(); advance();
        idle();
        reset = 1'b0;
        sample();
        chk("rst_mid_rd", mem_rd_cpu, 1'b0);
        chk("rst_mid_busy", cpu_busy, 1'b0);
        chk("rst_mid_ovr", cpu_overrun, 1'b0);
        advance();
        reset = 1'b1;
        sample();
        chk("rst_mid_noack", cpu_ack, 1'b0);
        advance();
        cpu_req = 1'b1; cpu_addr = 22'h0B0B0B;
        sample(); advance();
        idle();
        sample();
        chk("rst_ack_grant", mem_rd_cpu, 1'b1);
        advance();
        reset = 1'b0;
        sample();
        chk("rst_ack_killed", cpu_ack, 1'b0);
        advance();
        reset = 1'b1;

        // Randomised traffic against the model, including load_done dropouts.
        for (int i = 0; i < 3000; i++) begin
            load_done = (i % 150 < 8) ? 1'b0 : ($urandom_range(0, 15) != 0);
            cpu_req  = ($urandom_range(0, 2) == 0);
            cpu_we   = $urandom_range(0, 1) == 1;
            cpu_addr = 22'($urandom());
            cpu_d    = 8'($urandom());
            ppu_req  = ($urandom_range(0, 2) == 0);
            ppu_we   = $urandom_range(0, 1) == 1;
            ppu_addr = 22'($urandom());
            ppu_d    = 8'($urandom());
            sample();
            advance();
        end
        idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
